adv7511_cfg_sequencer: RTL and testbench
========================================

Name: adv7511_cfg_sequencer

Overview:
Power-up and hot-plug configuration controller for the ADV7511 HDMI transmitter that sits behind the video output path. It walks a fixed register table and issues one I2C register write per entry to the shared byte-level I2C master through a valid/ready command handshake, then waits for completion and retries on NACK. On success it asserts o_cfg_done, which gates o_adv_de/o_adv_clk enabling in aars_video_top. It re-runs the whole table on every HPD rising edge and on i_start.

Parameters:
C_STARTUP_CYCLES, 29600000, delay in clk cycles after reset release or HPD rise before the first write (200 ms at 148 MHz).
C_RETRY_CYCLES, 148000, back-off in clk cycles after a NACK before re-issuing the same entry (1 ms).
C_MAX_RETRY, 3, number of re-issues allowed per entry after its first NACK.
C_I2C_ADDR, 7'h39, 7-bit ADV7511 device address (8-bit form 0x72).

Ports:
clk  in  1  system clock (clk_wiz_0 clk_out1, 148 MHz)
sys_rst_n  in  1  asynchronous, active-low reset
i_hpd  in  1  ADV7511 hot-plug detect, asynchronous to clk
i_start  in  1  single-cycle pulse that forces a re-run of the table
o_cmd_valid  out  1  write command valid to the I2C master
i_cmd_ready  in  1  I2C master accepts the command
o_cmd_dev  out  7  device address, constant C_I2C_ADDR
o_cmd_reg  out  8  register address of the current entry
o_cmd_data  out  8  register data of the current entry
i_cmd_done  in  1  single-cycle pulse when the transaction ends
i_cmd_nack  in  1  valid only with i_cmd_done; 1 = transaction NACKed
o_busy  out  1  sequence in progress
o_cfg_done  out  1  full table written since the last (re)start
o_error  out  1  an entry exhausted its retries
o_index  out  4  current table index

Behaviour:
- Reset values: o_cmd_valid=0, o_cmd_reg=0, o_cmd_data=0, o_busy=0, o_cfg_done=0, o_error=0, o_index=0, FSM=WAIT_HPD, counters=0. o_cmd_dev=C_I2C_ADDR always.
- Synchronise i_hpd with a 2-flop synchroniser (reset 0). hpd_rise means synced=1 and previous synced=0.
- Register table, 12 entries, index 0..11, given as reg=data:
  41=10, 98=03, 9A=E0, 9C=30, 9D=61, A2=A4, A3=A4, E0=D0, F9=00, 15=00, 16=30, AF=04.
- FSM:
  - WAIT_HPD: go to DELAY when the synced HPD is 1, and clear the delay counter.
  - DELAY: count to C_STARTUP_CYCLES-1, then go to ISSUE with index 0 and retry=0. o_busy=1 in DELAY and in every state after it until IDLE or ERROR.
  - ISSUE: hold o_cmd_valid=1, with o_cmd_reg and o_cmd_data stable from table[index]. Transfer occurs on valid&&ready; on that cycle go to WAIT_ACK and drop valid on the next cycle.
  - WAIT_ACK, on i_cmd_done:
    - nack=0 and index=11: go to IDLE and set o_cfg_done=1.
    - nack=0 otherwise: index+1, retry=0, go to ISSUE.
    - nack=1 and retry<C_MAX_RETRY: retry+1, go to BACKOFF.
    - nack=1 otherwise: go to ERROR and set o_error=1.
  - BACKOFF: count C_RETRY_CYCLES, then go to ISSUE with the same index.
  - IDLE / ERROR: o_busy=0. Exit on hpd_rise or i_start: clear o_cfg_done and o_error, then go to WAIT_HPD.
- HPD falls (synced 0) in DELAY or BACKOFF: go to WAIT_HPD immediately and clear o_cfg_done.
- HPD falls in ISSUE or WAIT_ACK: finish the in-flight handshake first, i.e. never drop o_cmd_valid before it is accepted and always wait for i_cmd_done. Then go to WAIT_HPD.
- HPD falls in IDLE: clear o_cfg_done and go to WAIT_HPD.
- i_start while busy: latch it as a pending restart. At the next point where a transaction is not in flight, go to WAIT_HPD with index 0.
- An i_cmd_done outside WAIT_ACK is ignored.
- o_cfg_done and o_error are never 1 at the same time.
- Reset mid-transaction: all outputs return to reset values asynchronously. The I2C master is reset by the same sys_rst_n.

Test Plan:
- Clean boot (C_STARTUP_CYCLES=100, ready always 1, done 5 cycles after accept, no NACK), hpd=1 -> first o_cmd_valid 102-104 cycles after reset release; 12 writes in table order (41/10 ... AF/04); o_cfg_done=1 after the 12th done; o_busy=0.
- Backpressure: i_cmd_ready held 0 for 20 cycles -> o_cmd_valid stays 1 and o_cmd_reg/o_cmd_data stay unchanged for all 20 cycles; exactly one transfer occurs.
- NACK on index 3 (9C) twice, then ACK (C_RETRY_CYCLES=10) -> reg 9C issued 3 times, each ≥10 cycles apart; sequence completes with o_error=0.
- NACK on index 5 four times (C_MAX_RETRY=3) -> 4 attempts, then o_error=1, o_cfg_done=0, no further commands; then hpd low→high -> o_error clears and the full table re-runs from 41/10.
- HPD drop during WAIT_ACK at index 7 -> done is consumed, FSM goes to WAIT_HPD, o_cfg_done=0; HPD rise -> startup delay, then restart at index 0.
- Async reset asserted mid-ISSUE -> o_cmd_valid=0 and o_index=0 with no clk edge; after release the sequence restarts from WAIT_HPD.

Source files
------------

// File: rtl/adv7511_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adv7511_cfg_sequencer                                            |
// | Brief   : ADV7511 power-up / hot-plug register-table writer over a         |
// |           valid/ready I2C command interface, with NACK retry and back-off. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adv7511_cfg_sequencer #(
  parameter int         C_STARTUP_CYCLES = 29600000,
  parameter int         C_RETRY_CYCLES   = 148000,
  parameter int         C_MAX_RETRY      = 3,
  parameter logic [6:0] C_I2C_ADDR       = 7'h39
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       i_hpd,
  input  logic       i_start,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic [6:0] o_cmd_dev,
  output logic [7:0] o_cmd_reg,
  output logic [7:0] o_cmd_data,
  input  logic       i_cmd_done,
  input  logic       i_cmd_nack,
  output logic       o_busy,
  output logic       o_cfg_done,
  output logic       o_error,
  output logic [3:0] o_index
);

  localparam int c_CNT_MAX = (C_STARTUP_CYCLES > C_RETRY_CYCLES) ? C_STARTUP_CYCLES : C_RETRY_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_RTY_W   = $clog2(C_MAX_RETRY + 2);

  localparam logic [c_CNT_W-1:0] c_STARTUP_LAST = c_CNT_W'(C_STARTUP_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_RETRY_LAST   = c_CNT_W'(C_RETRY_CYCLES - 1);
  localparam logic [c_RTY_W-1:0] c_RETRY_MAX    = c_RTY_W'(C_MAX_RETRY);
  localparam logic [3:0]         c_LAST_IDX     = 4'd11;

  typedef enum logic [2:0] {
    S_WAIT_HPD = 3'd0,
    S_DELAY    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_BACKOFF  = 3'd4,
    S_IDLE     = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  // Register table, {register address, data}
  function automatic logic [15:0] f_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    f_entry = 16'h4110;
      4'd1:    f_entry = 16'h9803;
      4'd2:    f_entry = 16'h9AE0;
      4'd3:    f_entry = 16'h9C30;
      4'd4:    f_entry = 16'h9D61;
      4'd5:    f_entry = 16'hA2A4;
      4'd6:    f_entry = 16'hA3A4;
      4'd7:    f_entry = 16'hE0D0;
      4'd8:    f_entry = 16'hF900;
      4'd9:    f_entry = 16'h1500;
      4'd10:   f_entry = 16'h1630;
      4'd11:   f_entry = 16'hAF04;
      default: f_entry = 16'h0000;
    endcase
  endfunction

  state_t               r_state;
  logic                 r_hpd_s1;
  logic                 r_hpd_s2;
  logic                 r_hpd_prev;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [3:0]           r_index;
  logic [c_RTY_W-1:0]   r_retry;
  logic                 r_restart;
  logic                 r_cfg_done;
  logic                 r_error;
  logic [7:0]           r_cmd_reg;
  logic [7:0]           r_cmd_data;

  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [3:0]           w_index_nxt;
  logic [c_RTY_W-1:0]   w_retry_nxt;
  logic                 w_restart_nxt;
  logic                 w_cfg_done_nxt;
  logic                 w_error_nxt;
  logic [7:0]           w_cmd_reg_nxt;
  logic [7:0]           w_cmd_data_nxt;
  logic                 w_load;
  logic                 w_go_wait;
  logic                 w_busy;
  logic                 w_hpd_rise;
  logic                 w_restart_req;
  logic [15:0]          w_entry;

  assign w_busy        = (r_state == S_DELAY) || (r_state == S_ISSUE) ||
                         (r_state == S_WAIT_ACK) || (r_state == S_BACKOFF);
  assign w_hpd_rise    = r_hpd_s2 & ~r_hpd_prev;
  assign w_restart_req = r_restart | i_start;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_index_nxt    = r_index;
    w_retry_nxt    = r_retry;
    w_restart_nxt  = r_restart | (i_start & w_busy);
    w_cfg_done_nxt = r_cfg_done;
    w_error_nxt    = r_error;
    w_cmd_reg_nxt  = r_cmd_reg;
    w_cmd_data_nxt = r_cmd_data;
    w_load         = 1'b0;
    w_go_wait      = 1'b0;
    w_entry        = 16'h0000;

    case (r_state)
      S_WAIT_HPD: begin
        if (r_hpd_s2) begin
          w_state_nxt = S_DELAY;
          w_cnt_nxt   = '0;
        end
      end
      S_DELAY: begin
        if (!r_hpd_s2 || w_restart_req) begin
          w_go_wait = 1'b1;
        end else if (r_cnt == c_STARTUP_LAST) begin
          w_state_nxt = S_ISSUE;
          w_index_nxt = 4'd0;
          w_retry_nxt = '0;
          w_load      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_ISSUE: begin
        // Once valid is raised it is held until accepted, even if HPD drops.
        if (i_cmd_ready) begin
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (i_cmd_done) begin
          if (!r_hpd_s2 || r_restart) begin
            w_go_wait = 1'b1;
          end else if (!i_cmd_nack) begin
            if (r_index == c_LAST_IDX) begin
              w_state_nxt    = S_IDLE;
              w_cfg_done_nxt = 1'b1;
            end else begin
              w_state_nxt = S_ISSUE;
              w_index_nxt = r_index + 4'd1;
              w_retry_nxt = '0;
              w_load      = 1'b1;
            end
          end else if (r_retry < c_RETRY_MAX) begin
            w_state_nxt = S_BACKOFF;
            w_retry_nxt = r_retry + 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_ERROR;
            w_error_nxt = 1'b1;
          end
        end
      end
      S_BACKOFF: begin
        if (!r_hpd_s2 || w_restart_req) begin
          w_go_wait = 1'b1;
        end else if (r_cnt == c_RETRY_LAST) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (w_hpd_rise || i_start || !r_hpd_s2) begin
          w_go_wait = 1'b1;
        end
      end
      S_ERROR: begin
        if (w_hpd_rise || i_start) begin
          w_go_wait = 1'b1;
        end
      end
      default: begin
        w_go_wait = 1'b1;
      end
    endcase

    if (w_go_wait) begin
      w_state_nxt    = S_WAIT_HPD;
      w_cnt_nxt      = '0;
      w_index_nxt    = 4'd0;
      w_retry_nxt    = '0;
      w_restart_nxt  = 1'b0;
      w_cfg_done_nxt = 1'b0;
      w_error_nxt    = 1'b0;
    end

    // Command fields are captured on entry to ISSUE so they stay stable under backpressure.
    if (w_load) begin
      w_entry        = f_entry(w_index_nxt);
      w_cmd_reg_nxt  = w_entry[15:8];
      w_cmd_data_nxt = w_entry[7:0];
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hpd_s1   <= 1'b0;
      r_hpd_s2   <= 1'b0;
      r_hpd_prev <= 1'b0;
    end else begin
      r_hpd_s1   <= i_hpd;
      r_hpd_s2   <= r_hpd_s1;
      r_hpd_prev <= r_hpd_s2;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_WAIT_HPD;
      r_cnt      <= '0;
      r_index    <= 4'd0;
      r_retry    <= '0;
      r_restart  <= 1'b0;
      r_cfg_done <= 1'b0;
      r_error    <= 1'b0;
      r_cmd_reg  <= 8'h00;
      r_cmd_data <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_index    <= w_index_nxt;
      r_retry    <= w_retry_nxt;
      r_restart  <= w_restart_nxt;
      r_cfg_done <= w_cfg_done_nxt;
      r_error    <= w_error_nxt;
      r_cmd_reg  <= w_cmd_reg_nxt;
      r_cmd_data <= w_cmd_data_nxt;
    end
  end

  assign o_cmd_valid = (r_state == S_ISSUE);
  assign o_cmd_dev   = C_I2C_ADDR;
  assign o_cmd_reg   = r_cmd_reg;
  assign o_cmd_data  = r_cmd_data;
  assign o_busy      = w_busy;
  assign o_cfg_done  = r_cfg_done;
  assign o_error     = r_error;
  assign o_index     = r_index;

endmodule
`default_nettype wire

// File: tb/tb_adv7511_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_adv7511_cfg_sequencer                                         |
// | Brief   : Scoreboard bench with an I2C-master responder and table model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_adv7511_cfg_sequencer;

  localparam int C_STARTUP = 100;
  localparam int C_RETRY   = 10;
  localparam int C_MAXR    = 3;
  localparam logic [15:0] TBL [12] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30,
                                       16'h9D61, 16'hA2A4, 16'hA3A4, 16'hE0D0,
                                       16'hF900, 16'h1500, 16'h1630, 16'hAF04};

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       i_hpd;
  logic       i_start;
  logic       o_cmd_valid;
  logic       i_cmd_ready;
  logic [6:0] o_cmd_dev;
  logic [7:0] o_cmd_reg;
  logic [7:0] o_cmd_data;
  logic       i_cmd_done;
  logic       i_cmd_nack;
  logic       o_busy;
  logic       o_cfg_done;
  logic       o_error;
  logic [3:0] o_index;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          xfer_cnt = 0;
  int          done_lat = 5;
  int          rdy_mode = 1;
  int          plan [12];
  int          nack_left [12];
  logic [15:0] exp_q [$];
  time         t9c [$];

  always #5 clk = ~clk;

  adv7511_cfg_sequencer #(
    .C_STARTUP_CYCLES (C_STARTUP),
    .C_RETRY_CYCLES   (C_RETRY),
    .C_MAX_RETRY      (C_MAXR),
    .C_I2C_ADDR       (7'h39)
  ) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .i_hpd       (i_hpd),
    .i_start     (i_start),
    .o_cmd_valid (o_cmd_valid),
    .i_cmd_ready (i_cmd_ready),
    .o_cmd_dev   (o_cmd_dev),
    .o_cmd_reg   (o_cmd_reg),
    .o_cmd_data  (o_cmd_data),
    .i_cmd_done  (i_cmd_done),
    .i_cmd_nack  (i_cmd_nack),
    .o_busy      (o_busy),
    .o_cfg_done  (o_cfg_done),
    .o_error     (o_error),
    .o_index     (o_index)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: each entry is attempted once plus once per NACK, capped at
  // C_MAXR+1 attempts; running past the cap ends the table with an error.
  task automatic prep(input int upto, output bit err, output int n);
    int att;
    err = 0;
    n   = 0;
    nack_left = plan;
    for (int i = 0; i <= upto; i++) begin
      att = (plan[i] > C_MAXR) ? C_MAXR + 1 : plan[i] + 1;
      for (int k = 0; k < att; k++) begin
        exp_q.push_back(TBL[i]);
        n++;
      end
      if (plan[i] > C_MAXR) begin
        err = 1;
        break;
      end
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 12; i++) plan[i] = 0;
  endtask

  task automatic restart(input bit via_hpd);
    @(posedge clk); #1;
    if (via_hpd) begin
      i_hpd = 1'b0;
      repeat (6) @(posedge clk);
      #1 i_hpd = 1'b1;
      repeat (6) @(posedge clk);
      #1;
    end else begin
      i_start = 1'b1;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic end_checks(input string tag, input bit err, input int n, input int base);
    bit ok;
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (o_cfg_done || o_error) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_finished"}, 32'(ok), 1);
    repeat (3) @(negedge clk);
    chk({tag, "_cfg_done"}, 32'(o_cfg_done), 32'(!err));
    chk({tag, "_error"}, 32'(o_error), 32'(err));
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_xfers"}, xfer_cnt - base, n);
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Ready driver: 0 = held low, 1 = held high, 2 = random.
  initial begin
    i_cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       i_cmd_ready = 1'b0;
        1:       i_cmd_ready = 1'b1;
        default: i_cmd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // I2C master responder: done (optionally NACK) done_lat cycles after accept.
  initial begin
    int idx;
    bit nk;
    i_cmd_done = 1'b0;
    i_cmd_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (sys_rst_n && o_cmd_valid && i_cmd_ready) begin
        idx = -1;
        for (int k = 0; k < 12; k++) if (TBL[k][15:8] == o_cmd_reg) idx = k;
        nk = 0;
        if (idx >= 0 && nack_left[idx] > 0) begin
          nk = 1;
          nack_left[idx]--;
        end
        repeat (done_lat) @(posedge clk);
        #1 i_cmd_done = 1'b1;
        i_cmd_nack = nk;
        @(posedge clk);
        #1 i_cmd_done = 1'b0;
        i_cmd_nack = 1'b0;
      end
    end
  end

  // Monitor: every accepted command is popped from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (sys_rst_n && o_cmd_valid && i_cmd_ready) begin
        xfer_cnt++;
        if (o_cmd_reg == 8'h9C) t9c.push_back($time);
        chk("cmd_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("cmd_reg_data", {16'h0, o_cmd_reg, o_cmd_data}, {16'h0, exp_q.pop_front()});
        chk("cmd_dev", 32'(o_cmd_dev), 32'h39);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit err;
    int n;
    int base;
    int xb;
    int cyc;
    bit found;

    sys_rst_n = 1'b0;
    i_hpd     = 1'b1;
    i_start   = 1'b0;
    clear_plan();
    nack_left = plan;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_cmd_valid), 0);
    chk("rst_reg", 32'(o_cmd_reg), 0);
    chk("rst_data", 32'(o_cmd_data), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_cfg_done", 32'(o_cfg_done), 0);
    chk("rst_error", 32'(o_error), 0);
    chk("rst_index", 32'(o_index), 0);
    chk("rst_dev", 32'(o_cmd_dev), 32'h39);

    // Clean boot with HPD already high
    prep(11, err, n);
    base = xfer_cnt;
    @(posedge clk); #1 sys_rst_n = 1'b1;
    cyc = 0;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (o_cmd_valid) begin
        found = 1;
        break;
      end
    end
    chk("boot_first_valid_seen", 32'(found), 1);
    chk("boot_first_valid_window", 32'(cyc >= 102 && cyc <= 104), 1);
    end_checks("boot", err, n, base);

    // Backpressure on the first command
    clear_plan();
    prep(11, err, n);
    base = xfer_cnt;
    rdy_mode = 0;
    restart(0);
    found = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (o_cmd_valid) begin
        found = 1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(found), 1);
    xb = xfer_cnt;
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid_held", 32'(o_cmd_valid), 1);
      chk("bp_entry_stable", {16'h0, o_cmd_reg, o_cmd_data}, {16'h0, TBL[0]});
      @(negedge clk);
    end
    chk("bp_no_xfer_blocked", xfer_cnt - xb, 0);
    rdy_mode = 1;
    end_checks("bp", err, n, base);

    // Index 3 NACKed twice, then ACKed
    clear_plan();
    plan[3] = 2;
    prep(11, err, n);
    base = xfer_cnt;
    t9c.delete();
    restart(1);
    end_checks("nack3", err, n, base);
    chk("nack3_attempts", t9c.size(), 3);
    for (int i = 1; i < t9c.size(); i++)
      chk("nack3_spacing", 32'((t9c[i] - t9c[i-1]) >= 10 * C_RETRY), 1);

    // Index 5 exhausts its retries
    clear_plan();
    plan[5] = 4;
    prep(11, err, n);
    base = xfer_cnt;
    restart(0);
    end_checks("nack5", err, n, base);
    xb = xfer_cnt;
    repeat (50) @(negedge clk);
    chk("err_no_more_cmds", xfer_cnt - xb, 0);
    chk("err_held", 32'(o_error), 1);
    clear_plan();
    prep(11, err, n);
    base = xfer_cnt;
    restart(1);
    chk("err_cleared_on_hpd", 32'(o_error), 0);
    end_checks("err_rerun", err, n, base);

    // HPD drop while index 7 is awaiting completion
    clear_plan();
    done_lat = 20;
    prep(7, err, n);
    base = xfer_cnt;
    restart(0);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (xfer_cnt - base >= 8) begin
        found = 1;
        break;
      end
    end
    chk("hpd_drop_reached_idx7", 32'(found), 1);
    @(posedge clk); #1 i_hpd = 1'b0;
    repeat (10) @(negedge clk);
    chk("hpd_drop_busy_inflight", 32'(o_busy), 1);
    repeat (30) @(negedge clk);
    chk("hpd_drop_busy", 32'(o_busy), 0);
    chk("hpd_drop_cfg_done", 32'(o_cfg_done), 0);
    chk("hpd_drop_xfers", xfer_cnt - base, 8);
    chk("hpd_drop_sb_empty", exp_q.size(), 0);
    done_lat = 5;
    prep(11, err, n);
    base = xfer_cnt;
    @(posedge clk); #1 i_hpd = 1'b1;
    end_checks("hpd_rerun", err, n, base);

    // Randomised NACK plans, completion latency and backpressure
    rdy_mode = 2;
    for (int it = 0; it < 6; it++) begin
      int r;
      for (int i = 0; i < 12; i++) begin
        r = $urandom_range(0, 19);
        plan[i] = (r < 14) ? 0 : (r < 18) ? $urandom_range(1, 3) : 4;
      end
      done_lat = $urandom_range(1, 6);
      prep(11, err, n);
      base = xfer_cnt;
      restart(it[0]);
      end_checks("rand", err, n, base);
    end
    rdy_mode = 1;
    done_lat = 5;

    // Asynchronous reset while index 4 is held in ISSUE
    clear_plan();
    prep(11, err, n);
    base = xfer_cnt;
    restart(0);
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (xfer_cnt - base >= 4) begin
        found = 1;
        break;
      end
    end
    @(posedge clk); #1 rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_cmd_valid && o_index == 4'd4) begin
        found = found & 1'b1;
        break;
      end
    end
    chk("arst_in_issue_idx4", {31'h0, o_cmd_valid} + 32'(o_index), 5);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_cmd_valid), 0);
    chk("arst_index", 32'(o_index), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_reg", 32'(o_cmd_reg), 0);
    exp_q.delete();
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    prep(11, err, n);
    base = xfer_cnt;
    #1 sys_rst_n = 1'b1;
    end_checks("arst_rerun", err, n, base);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
